// File: rtl/runs_pkg.sv
// rtl/runs_pkg.sv - shared frame geometry, FSM states and health-checker limits
package runs_pkg;

  localparam int N = 20000;
  localparam int W = 15;

  // Acceptance window of the monobit/runs checker; a frame passes only when
  // both its ones count and its runs count fall inside these inclusive bounds.
  localparam int ONES_MIN = 9818;
  localparam int ONES_MAX = 10181;
  localparam int RUNS_MIN = 9815;
  localparam int RUNS_MAX = 10179;

  typedef enum logic [2:0] {
    IDLE,
    PLAN,
    LONG1,
    LONG0,
    ALT,
    DONE
  } state_e;

endpackage

// File: rtl/runs_gen_plan.sv
// rtl/runs_gen_plan.sv - turns targets K/R into run lengths and a feasibility flag
module runs_gen_plan #(
  parameter int N = runs_pkg::N,
  parameter int W = runs_pkg::W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] k,
  input  logic [W-1:0] r,
  output logic [W-1:0] len1,
  output logic [W-1:0] len0,
  output logic [W-1:0] alt_len,
  output logic         err
);

  localparam logic [W-1:0] NW = W'(N);

  logic [W:0]   ro;
  logic [W-1:0] rz;
  logic [W-1:0] z;

  logic [W-1:0] len1_d, len1_q;
  logic [W-1:0] len0_d, len0_q;
  logic [W-1:0] alt_len_d, alt_len_q;
  logic         err_d, err_q;

  always_comb begin
    // One extra bit keeps (R+1)>>1 exact when R is all ones.
    ro        = ({1'b0, r} + (W+1)'(1)) >> 1;
    rz        = r >> 1;
    z         = NW - k;
    len1_d    = len1_q;
    len0_d    = len0_q;
    alt_len_d = alt_len_q;
    err_d     = err_q;
    if (load) begin
      err_d = (k == '0) || (r == '0) || (k > NW) || (ro > {1'b0, k}) ||
              (rz > z) || ((rz == '0) && (z != '0));
      len1_d    = k - ro[W-1:0] + W'(1);
      len0_d    = (rz == '0) ? '0 : (z - rz + W'(1));
      alt_len_d = (r >= W'(2)) ? (r - W'(2)) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len1_q    <= '0;
      len0_q    <= '0;
      alt_len_q <= '0;
      err_q     <= 1'b0;
    end else begin
      len1_q    <= len1_d;
      len0_q    <= len0_d;
      alt_len_q <= alt_len_d;
      err_q     <= err_d;
    end
  end

  assign len1    = len1_q;
  assign len0    = len0_q;
  assign alt_len = alt_len_q;
  assign err     = err_q;

endmodule

// File: rtl/runs_pattern_gen.sv
// rtl/runs_pattern_gen.sv - emits one N-bit frame holding exactly K ones and R runs
module runs_pattern_gen #(
  parameter int N = runs_pkg::N,
  parameter int W = runs_pkg::W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] target_ones,
  input  logic [W-1:0] target_runs,
  output logic         bit_out,
  output logic         bit_valid,
  output logic         sof,
  output logic         eof,
  output logic         busy,
  output logic         done,
  output logic         cfg_err
);

  import runs_pkg::*;

  localparam logic [W-1:0] LAST_IDX = W'(N - 1);

  state_e       state_q, state_d;
  logic [W-1:0] run_cnt_q, run_cnt_d;
  logic [W-1:0] alt_cnt_q, alt_cnt_d;
  logic [W-1:0] bit_idx_q, bit_idx_d;
  logic         alt_bit_q, alt_bit_d;
  logic         err_pend_q, err_pend_d;

  logic         bit_out_q, bit_out_d;
  logic         bit_valid_q, bit_valid_d;
  logic         sof_q, sof_d;
  logic         eof_q, eof_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         cfg_err_q, cfg_err_d;

  logic         plan_load;
  logic [W-1:0] len1, len0, alt_len;
  logic         plan_err;
  logic         emit, emit_val;

  runs_gen_plan #(
    .N (N),
    .W (W)
  ) u_plan (
    .clk     (clk),
    .rst     (rst),
    .load    (plan_load),
    .k       (target_ones),
    .r       (target_runs),
    .len1    (len1),
    .len0    (len0),
    .alt_len (alt_len),
    .err     (plan_err)
  );

  always_comb begin
    state_d    = state_q;
    run_cnt_d  = run_cnt_q;
    alt_cnt_d  = alt_cnt_q;
    alt_bit_d  = alt_bit_q;
    bit_idx_d  = bit_idx_q;
    err_pend_d = 1'b0;
    plan_load  = 1'b0;
    emit       = 1'b0;
    emit_val   = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          plan_load = 1'b1;
          state_d   = PLAN;
        end
      end
      PLAN: begin
        if (plan_err) begin
          err_pend_d = 1'b1;
          state_d    = IDLE;
        end else begin
          run_cnt_d = len1;
          bit_idx_d = '0;
          state_d   = LONG1;
        end
      end
      LONG1: begin
        emit      = 1'b1;
        emit_val  = 1'b1;
        run_cnt_d = run_cnt_q - W'(1);
        if (run_cnt_q == W'(1)) begin
          if (len0 != '0) begin
            run_cnt_d = len0;
            state_d   = LONG0;
          end else begin
            state_d = DONE;
          end
        end
      end
      LONG0: begin
        emit      = 1'b1;
        emit_val  = 1'b0;
        run_cnt_d = run_cnt_q - W'(1);
        if (run_cnt_q == W'(1)) begin
          if (alt_len != '0) begin
            alt_cnt_d = alt_len;
            alt_bit_d = 1'b1;
            state_d   = ALT;
          end else begin
            state_d = DONE;
          end
        end
      end
      ALT: begin
        emit      = 1'b1;
        emit_val  = alt_bit_q;
        alt_bit_d = ~alt_bit_q;
        alt_cnt_d = alt_cnt_q - W'(1);
        if (alt_cnt_q == W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (emit) begin
      bit_idx_d = bit_idx_q + W'(1);
    end

    // Outputs are registered, so every flag trails the state that produced it by one edge.
    bit_valid_d = emit;
    bit_out_d   = emit & emit_val;
    sof_d       = emit && (bit_idx_q == '0);
    eof_d       = emit && (bit_idx_q == LAST_IDX);
    busy_d      = (state_q != IDLE);
    cfg_err_d   = err_pend_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      run_cnt_q   <= '0;
      alt_cnt_q   <= '0;
      bit_idx_q   <= '0;
      alt_bit_q   <= 1'b0;
      err_pend_q  <= 1'b0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_cnt_q   <= run_cnt_d;
      alt_cnt_q   <= alt_cnt_d;
      bit_idx_q   <= bit_idx_d;
      alt_bit_q   <= alt_bit_d;
      err_pend_q  <= err_pend_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
      sof_q       <= sof_d;
      eof_q       <= eof_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  // The run structure and the bit index must run out on the same bit.
  eof_matches_structure: assert property (
    @(posedge clk) disable iff (rst)
    emit |-> ((state_d == DONE) == (bit_idx_q == LAST_IDX))
  );

  assign bit_out   = bit_out_q;
  assign bit_valid = bit_valid_q;
  assign sof       = sof_q;
  assign eof       = eof_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_runs_pattern_gen.sv
// tb/tb_runs_pattern_gen.sv - randomized self-checking bench for runs_pattern_gen
module tb_runs_pattern_gen;

  import runs_pkg::*;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] target_ones;
  logic [W-1:0] target_runs;
  logic         bit_out, bit_valid, sof, eof, busy, done, cfg_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  bit exp_q[$];
  bit obs_q[$];

  runs_pattern_gen #(
    .N (N),
    .W (W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .target_ones (target_ones),
    .target_runs (target_runs),
    .bit_out     (bit_out),
    .bit_valid   (bit_valid),
    .sof         (sof),
    .eof         (eof),
    .busy        (busy),
    .done        (done),
    .cfg_err     (cfg_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit feasible(input int k, input int r);
    int z, ro, rz;
    z  = N - k;
    ro = (r + 1) / 2;
    rz = r / 2;
    if (k == 0 || r == 0 || k > N) return 1'b0;
    if (ro > k || rz > z) return 1'b0;
    if (rz == 0 && z != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Reference frame: a list of run lengths, expanded with alternating polarity starting at 1.
  function automatic void plan_frame(input int k, input int r);
    int runs[$];
    int ones_runs, zero_runs;
    exp_q.delete();
    ones_runs = (r + 1) / 2;
    zero_runs = r / 2;
    runs.push_back(k - ones_runs + 1);
    if (zero_runs > 0) runs.push_back(N - k - zero_runs + 1);
    for (int i = 0; i < r - 2; i++) runs.push_back(1);
    foreach (runs[i]) begin
      for (int j = 0; j < runs[i]; j++) exp_q.push_back(i % 2 == 0);
    end
  endfunction

  function automatic int count_ones();
    int n = 0;
    foreach (obs_q[i]) n += int'(obs_q[i]);
    return n;
  endfunction

  function automatic int count_runs();
    int n = 0;
    foreach (obs_q[i]) if (i == 0 || obs_q[i] != obs_q[i-1]) n++;
    return n;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    target_ones = '0;
    target_runs = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({bit_out, bit_valid, sof, eof, busy, done, cfg_err} !== 7'b0) begin
      bad++;
      $display("FAIL reset_outputs: got %b want 0000000", {bit_out, bit_valid, sof, eof, busy, done, cfg_err});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({bit_out, bit_valid, sof, eof, busy, done, cfg_err} !== 7'b0) begin
      bad++;
      $display("FAIL idle_outputs: got %b want 0000000", {bit_out, bit_valid, sof, eof, busy, done, cfg_err});
    end
  endtask

  task automatic test_cfg_err(input int k, input int r);
    int t, rel, cfg_rel, n_cfg, n_valid, exp_rel;
    bit busy1, busy2;
    n_cfg = 0; n_valid = 0; cfg_rel = -1; busy1 = 1'b0; busy2 = 1'b1;
    exp_rel = feasible(k, r) ? -1 : 2;
    @(negedge clk);
    target_ones = W'(k);
    target_runs = W'(r);
    start = 1'b1;
    @(negedge clk);
    t = cyc;
    start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      rel = cyc - t;
      if (cfg_err) begin n_cfg++; cfg_rel = rel; end
      if (bit_valid) n_valid++;
      if (rel == 1) busy1 = busy;
      if (rel == 2) busy2 = busy;
    end
    total++;
    if (n_cfg !== (exp_rel < 0 ? 0 : 1) || cfg_rel !== exp_rel) begin
      bad++;
      $display("FAIL cfg_err_k%0d_r%0d: got cycle %0d (x%0d) want cycle %0d", k, r, cfg_rel, n_cfg, exp_rel);
    end
    if (exp_rel >= 0) begin
      total++;
      if (n_valid !== 0 || busy1 !== 1'b1 || busy2 !== 1'b0) begin
        bad++;
        $display("FAIL cfg_err_side_k%0d_r%0d: got valid=%0d busy1=%0d busy2=%0d want 0 1 0", k, r, n_valid, busy1, busy2);
      end
    end else begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
    end
  endtask

  task automatic test_random_cfg();
    int k, r, sel;
    for (int n = 0; n < 10; n++) begin
      sel = int'($urandom_range(0, 5));
      case (sel)
        0: begin k = 0; r = int'($urandom_range(1, N)); end
        1: begin k = int'($urandom_range(1, N)); r = 0; end
        2: begin k = int'($urandom_range(N + 1, 32767)); r = int'($urandom_range(1, 32767)); end
        3: begin k = int'($urandom_range(1, 5000)); r = 2 * k + 1 + int'($urandom_range(0, 100)); end
        4: begin k = int'($urandom_range(N - 100, N - 1)); r = 2 * (N - k + 1) + int'($urandom_range(0, 1)); end
        default: begin k = int'($urandom_range(1, N - 1)); r = 1; end
      endcase
      test_cfg_err(k, r);
    end
  endtask

  task automatic run_frame(input int k, input int r, input bit exp_pass, input int abort_bit);
    int t, rel, limit, n_sof, sof_rel, n_eof, eof_rel, n_done, done_rel, n_cfg;
    int busy_first, busy_last, stray_valid, stray_bit, bit_bad, first_bad, ones, runs, n_after;
    bit got_pass;
    obs_q.delete();
    plan_frame(k, r);
    n_sof = 0; n_eof = 0; n_done = 0; n_cfg = 0;
    sof_rel = -1; eof_rel = -1; done_rel = -1;
    busy_first = -1; busy_last = -1; stray_valid = 0; stray_bit = 0;
    @(negedge clk);
    target_ones = W'(k);
    target_runs = W'(r);
    start = 1'b1;
    @(negedge clk);
    t = cyc;
    start = 1'b0;
    limit = (abort_bit >= 0) ? abort_bit + 2 : N + 3;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      rel = cyc - t;
      if (bit_valid) obs_q.push_back(bit_out);
      else if (bit_out) stray_bit++;
      if (bit_valid && (rel < 2 || rel > N + 1)) stray_valid++;
      if (sof) begin n_sof++; sof_rel = rel; end
      if (eof) begin n_eof++; eof_rel = rel; end
      if (done) begin n_done++; done_rel = rel; end
      if (cfg_err) n_cfg++;
      if (busy) begin
        if (busy_first < 0) busy_first = rel;
        busy_last = rel;
      end
      // Retargeting and restarting while the frame is in flight must not disturb it.
      target_ones = W'($urandom_range(0, 32767));
      target_runs = W'($urandom_range(0, 32767));
      start = (rel + 1 <= N + 2) && ($urandom_range(0, 7) == 0);
    end
    start = 1'b0;

    bit_bad = 0; first_bad = -1;
    foreach (obs_q[i]) begin
      if (i < exp_q.size() && obs_q[i] != exp_q[i]) begin
        if (first_bad < 0) first_bad = i;
        bit_bad++;
      end
    end

    if (abort_bit >= 0) begin
      rst = 1'b1;
      @(negedge clk);
      total++;
      if ({bit_out, bit_valid, sof, eof, busy, done, cfg_err} !== 7'b0) begin
        bad++;
        $display("FAIL abort_outputs: got %b want 0000000", {bit_out, bit_valid, sof, eof, busy, done, cfg_err});
      end
      rst = 1'b0;
      total++;
      if (obs_q.size() !== abort_bit + 1 || bit_bad !== 0) begin
        bad++;
        $display("FAIL abort_prefix: got %0d bits, %0d wrong (first %0d) want %0d bits, 0 wrong", obs_q.size(), bit_bad, first_bad, abort_bit + 1);
      end
      n_after = 0;
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        if (done || eof || bit_valid || busy) n_after++;
      end
      total++;
      if (n_after !== 0) begin
        bad++;
        $display("FAIL abort_quiet: got %0d active cycles want 0", n_after);
      end
      return;
    end

    ones = count_ones();
    runs = count_runs();
    got_pass = (ones >= ONES_MIN) && (ones <= ONES_MAX) && (runs >= RUNS_MIN) && (runs <= RUNS_MAX);

    total++;
    if (obs_q.size() !== N || stray_valid !== 0) begin
      bad++;
      $display("FAIL valid_count_k%0d_r%0d: got %0d bits, %0d outside window want %0d, 0", k, r, obs_q.size(), stray_valid, N);
    end
    total++;
    if (bit_bad !== 0) begin
      bad++;
      $display("FAIL pattern_k%0d_r%0d: got %0d wrong bits (first at %0d) want 0", k, r, bit_bad, first_bad);
    end
    total++;
    if (stray_bit !== 0) begin
      bad++;
      $display("FAIL bit_out_idle_k%0d_r%0d: got %0d cycles want 0", k, r, stray_bit);
    end
    total++;
    if (n_sof !== 1 || sof_rel !== 2) begin
      bad++;
      $display("FAIL sof_k%0d_r%0d: got t+%0d (x%0d) want t+2", k, r, sof_rel, n_sof);
    end
    total++;
    if (n_eof !== 1 || eof_rel !== N + 1) begin
      bad++;
      $display("FAIL eof_k%0d_r%0d: got t+%0d (x%0d) want t+%0d", k, r, eof_rel, n_eof, N + 1);
    end
    total++;
    if (n_done !== 1 || done_rel !== N + 2) begin
      bad++;
      $display("FAIL done_k%0d_r%0d: got t+%0d (x%0d) want t+%0d", k, r, done_rel, n_done, N + 2);
    end
    total++;
    if (busy_first !== 1 || busy_last !== N + 2) begin
      bad++;
      $display("FAIL busy_k%0d_r%0d: got t+%0d..t+%0d want t+1..t+%0d", k, r, busy_first, busy_last, N + 2);
    end
    total++;
    if (n_cfg !== 0) begin
      bad++;
      $display("FAIL cfg_err_in_frame_k%0d_r%0d: got %0d want 0", k, r, n_cfg);
    end
    total++;
    if (ones !== k) begin
      bad++;
      $display("FAIL ones_k%0d_r%0d: got %0d want %0d", k, r, ones, k);
    end
    total++;
    if (runs !== r) begin
      bad++;
      $display("FAIL runs_k%0d_r%0d: got %0d want %0d", k, r, runs, r);
    end
    total++;
    if (obs_q.size() > 0 && obs_q[obs_q.size() - 1] !== exp_q[N - 1]) begin
      bad++;
      $display("FAIL last_bit_k%0d_r%0d: got %0d want %0d", k, r, obs_q[obs_q.size() - 1], exp_q[N - 1]);
    end
    total++;
    if (got_pass !== exp_pass) begin
      bad++;
      $display("FAIL checker_pass_k%0d_r%0d: got %0d want %0d", k, r, got_pass, exp_pass);
    end
  endtask

  task automatic test_frame_even();
    run_frame(10000, 10000, 1'b1, -1);
  endtask

  task automatic test_frame_odd_boundary();
    run_frame(10181, 10179, 1'b1, -1);
  endtask

  task automatic test_all_ones();
    run_frame(N, 1, 1'b0, -1);
  endtask

  task automatic test_reset_mid_frame();
    run_frame(9818, 9814, 1'b0, 7000);
    run_frame(9818, 9815, 1'b1, -1);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    target_ones = '0;
    target_runs = '0;
    test_reset();
    test_cfg_err(5, 20);
    test_cfg_err(N, 32767);
    test_random_cfg();
    test_frame_even();
    test_frame_odd_boundary();
    test_all_ones();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
